// File: rtl/axil_sub_arbiter.sv
// Two-requester AXI-Lite arbiter: independent round-robin write and read
// paths, one outstanding transaction per path, sharing one downstream port.
module axil_sub_arbiter #(
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXILSizeBytes   = AXIL_DATA_WIDTH / 8
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    // requester side, requester n in slice n
    input  logic [2*AXIL_ADDR_WIDTH-1:0] req_aw_addr_i,
    input  logic [5:0]                   req_aw_prot_i,
    input  logic [1:0]                   req_aw_valid_i,
    output logic [1:0]                   req_aw_ready_o,
    input  logic [2*AXIL_DATA_WIDTH-1:0] req_w_data_i,
    input  logic [2*AXILSizeBytes-1:0]   req_w_strb_i,
    input  logic [1:0]                   req_w_valid_i,
    output logic [1:0]                   req_w_ready_o,
    output logic [3:0]                   req_b_resp_o,
    output logic [1:0]                   req_b_valid_o,
    input  logic [1:0]                   req_b_ready_i,
    input  logic [2*AXIL_ADDR_WIDTH-1:0] req_ar_addr_i,
    input  logic [5:0]                   req_ar_prot_i,
    input  logic [1:0]                   req_ar_valid_i,
    output logic [1:0]                   req_ar_ready_o,
    output logic [2*AXIL_DATA_WIDTH-1:0] req_r_data_o,
    output logic [3:0]                   req_r_resp_o,
    output logic [1:0]                   req_r_valid_o,
    input  logic [1:0]                   req_r_ready_i,
    // downstream write path
    output logic [AXIL_ADDR_WIDTH-1:0]   sub_aw_addr_o,
    output logic [2:0]                   sub_aw_prot_o,
    output logic                         sub_aw_valid_o,
    input  logic                         sub_aw_ready_i,
    output logic [AXIL_DATA_WIDTH-1:0]   sub_w_data_o,
    output logic [AXILSizeBytes-1:0]     sub_w_strb_o,
    output logic                         sub_w_valid_o,
    input  logic                         sub_w_ready_i,
    input  logic [1:0]                   sub_b_resp_i,
    input  logic                         sub_b_valid_i,
    output logic                         sub_b_ready_o,
    // downstream read path
    output logic [AXIL_ADDR_WIDTH-1:0]   sub_ar_addr_o,
    output logic [2:0]                   sub_ar_prot_o,
    output logic                         sub_ar_valid_o,
    input  logic                         sub_ar_ready_i,
    input  logic [AXIL_DATA_WIDTH-1:0]   sub_r_data_i,
    input  logic [1:0]                   sub_r_resp_i,
    input  logic                         sub_r_valid_i,
    output logic                         sub_r_ready_o,
    // current grants, one-hot, zero when idle
    output logic [1:0]                   wr_gnt_o,
    output logic [1:0]                   rd_gnt_o
);

    localparam int unsigned AW = AXIL_ADDR_WIDTH;
    localparam int unsigned DW = AXIL_DATA_WIDTH;
    localparam int unsigned SW = AXILSizeBytes;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic      wr_idx_q, wr_idx_d;
    logic      rd_idx_q, rd_idx_d;
    logic      last_wr_q, last_wr_d;
    logic      last_rd_q, last_rd_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;

    // Round-robin pick: on a tie the requester not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    // Granted requester's slices.
    logic [AW-1:0] aw_addr_sel, ar_addr_sel;
    logic [2:0]    aw_prot_sel, ar_prot_sel;
    logic [DW-1:0] w_data_sel;
    logic [SW-1:0] w_strb_sel;
    logic          aw_valid_sel, w_valid_sel, b_ready_sel, ar_valid_sel, r_ready_sel;
    logic [1:0]    wr_onehot, rd_onehot;

    assign aw_addr_sel  = wr_idx_q ? req_aw_addr_i[2*AW-1:AW] : req_aw_addr_i[AW-1:0];
    assign aw_prot_sel  = wr_idx_q ? req_aw_prot_i[5:3] : req_aw_prot_i[2:0];
    assign w_data_sel   = wr_idx_q ? req_w_data_i[2*DW-1:DW] : req_w_data_i[DW-1:0];
    assign w_strb_sel   = wr_idx_q ? req_w_strb_i[2*SW-1:SW] : req_w_strb_i[SW-1:0];
    assign aw_valid_sel = req_aw_valid_i[wr_idx_q];
    assign w_valid_sel  = req_w_valid_i[wr_idx_q];
    assign b_ready_sel  = req_b_ready_i[wr_idx_q];
    assign ar_addr_sel  = rd_idx_q ? req_ar_addr_i[2*AW-1:AW] : req_ar_addr_i[AW-1:0];
    assign ar_prot_sel  = rd_idx_q ? req_ar_prot_i[5:3] : req_ar_prot_i[2:0];
    assign ar_valid_sel = req_ar_valid_i[rd_idx_q];
    assign r_ready_sel  = req_r_ready_i[rd_idx_q];
    assign wr_onehot    = wr_idx_q ? 2'b10 : 2'b01;
    assign rd_onehot    = rd_idx_q ? 2'b10 : 2'b01;

    // State registers for both paths.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_idx_q   <= 1'b0;
            rd_idx_q   <= 1'b0;
            last_wr_q  <= 1'b1;
            last_rd_q  <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            last_wr_q  <= last_wr_d;
            last_rd_q  <= last_rd_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Write path: arbitration, AW/W pass-through with done masking, B routing.
    always_comb begin
        logic aw_hs;
        logic w_hs;
        wr_state_d     = wr_state_q;
        wr_idx_d       = wr_idx_q;
        last_wr_d      = last_wr_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        wr_gnt_o       = 2'b00;
        sub_aw_addr_o  = '0;
        sub_aw_prot_o  = '0;
        sub_aw_valid_o = 1'b0;
        sub_w_data_o   = '0;
        sub_w_strb_o   = '0;
        sub_w_valid_o  = 1'b0;
        sub_b_ready_o  = 1'b0;
        req_aw_ready_o = 2'b00;
        req_w_ready_o  = 2'b00;
        req_b_valid_o  = 2'b00;
        req_b_resp_o   = '0;
        if (wr_state_q != W_IDLE) begin
            wr_gnt_o      = wr_onehot;
            sub_aw_addr_o = aw_addr_sel;
            sub_aw_prot_o = aw_prot_sel;
            sub_w_data_o  = w_data_sel;
            sub_w_strb_o  = w_strb_sel;
        end
        case (wr_state_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|req_aw_valid_i) begin
                    wr_idx_d   = rr_pick(req_aw_valid_i, last_wr_q);
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                sub_aw_valid_o = aw_valid_sel & ~aw_done_q;
                sub_w_valid_o  = w_valid_sel & ~w_done_q;
                req_aw_ready_o = wr_onehot & {2{sub_aw_ready_i & ~aw_done_q}};
                req_w_ready_o  = wr_onehot & {2{sub_w_ready_i & ~w_done_q}};
                aw_hs          = sub_aw_valid_o & sub_aw_ready_i;
                w_hs           = sub_w_valid_o & sub_w_ready_i;
                aw_done_d      = aw_done_q | aw_hs;
                w_done_d       = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                sub_b_ready_o = b_ready_sel;
                req_b_valid_o = wr_onehot & {2{sub_b_valid_i}};
                req_b_resp_o  = {2{sub_b_resp_i}};
                if (sub_b_valid_i && b_ready_sel) begin
                    last_wr_d  = wr_idx_q;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read path: arbitration, AR pass-through, R routing.
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_idx_d       = rd_idx_q;
        last_rd_d      = last_rd_q;
        rd_gnt_o       = 2'b00;
        sub_ar_addr_o  = '0;
        sub_ar_prot_o  = '0;
        sub_ar_valid_o = 1'b0;
        sub_r_ready_o  = 1'b0;
        req_ar_ready_o = 2'b00;
        req_r_valid_o  = 2'b00;
        req_r_data_o   = '0;
        req_r_resp_o   = '0;
        if (rd_state_q != R_IDLE) begin
            rd_gnt_o      = rd_onehot;
            sub_ar_addr_o = ar_addr_sel;
            sub_ar_prot_o = ar_prot_sel;
        end
        case (rd_state_q)
            R_IDLE: begin
                if (|req_ar_valid_i) begin
                    rd_idx_d   = rr_pick(req_ar_valid_i, last_rd_q);
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                sub_ar_valid_o = ar_valid_sel;
                req_ar_ready_o = rd_onehot & {2{sub_ar_ready_i}};
                if (ar_valid_sel && sub_ar_ready_i) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                sub_r_ready_o = r_ready_sel;
                req_r_valid_o = rd_onehot & {2{sub_r_valid_i}};
                req_r_data_o  = {2{sub_r_data_i}};
                req_r_resp_o  = {2{sub_r_resp_i}};
                if (sub_r_valid_i && r_ready_sel) begin
                    last_rd_d  = rd_idx_q;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

endmodule
